// File: rtl/countdown_cmd_gen.sv
// Command generator for the slow-edge down-counter: turns load/pause requests into
// start_val/enable/inc controls held stable until the next slow_edge strobe.
module countdown_cmd_gen #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             slow_edge,
    input  logic             load_req,
    input  logic [WIDTH-1:0] load_val,
    input  logic             plus_one,
    input  logic             hold_req,
    input  logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] start_val,
    output logic             enable,
    output logic             inc,
    output logic             armed,
    output logic             running,
    output logic             expired
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_RUN     = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] start_val_q;
    logic             plus_one_q;
    logic             hold_q;
    logic             expired_q;
    logic             count_zero;

    assign count_zero = (count == '0);

    // A new load always wins, including over a terminating strobe.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ST_IDLE;
            start_val_q <= '0;
            plus_one_q  <= 1'b0;
            hold_q      <= 1'b0;
            expired_q   <= 1'b0;
        end else begin
            hold_q    <= hold_req;
            expired_q <= 1'b0;
            if (load_req) begin
                start_val_q <= load_val;
                plus_one_q  <= plus_one;
                state       <= ST_ARMED;
            end else begin
                unique case (state)
                    ST_ARMED: begin
                        if (slow_edge) begin
                            state <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (slow_edge && count_zero && !hold_q) begin
                            state     <= ST_EXPIRED;
                            expired_q <= 1'b1;
                        end
                    end
                    default: begin
                        state <= state;
                    end
                endcase
            end
        end
    end

    // count==0 enters inc directly so the counter freezes on the strobe that would wrap it.
    always_comb begin
        inc = 1'b1;
        unique case (state)
            ST_ARMED: inc = plus_one_q;
            ST_RUN:   inc = hold_q | count_zero;
            default:  inc = 1'b1;
        endcase
    end

    assign start_val = start_val_q;
    assign enable    = (state == ST_ARMED);
    assign armed     = (state == ST_ARMED);
    assign running   = (state == ST_RUN);
    assign expired   = expired_q;

endmodule

// File: tb/tb_countdown_cmd_gen.sv
// Bench for countdown_cmd_gen: a behavioural counter plant driven by the DUT plus a
// timer-level reference model of what the count and status outputs should be.
module tb_countdown_cmd_gen;

    logic       clk;
    logic       reset;
    logic       slow_edge;
    logic       load_req;
    logic [7:0] load_val;
    logic       plus_one;
    logic       hold_req;
    logic [7:0] cnt;
    logic [7:0] start_val;
    logic       enable;
    logic       inc;
    logic       armed;
    logic       running;
    logic       expired;

    int n_vec;
    int n_err;
    int exp_pulses;

    // reference model: an ideal countdown timer
    bit m_pending;
    bit m_counting;
    bit m_pulse;
    bit m_hold_prev;
    bit m_pp;
    int m_pv;
    int m_sv;
    int m_timer;

    countdown_cmd_gen #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .slow_edge (slow_edge),
        .load_req  (load_req),
        .load_val  (load_val),
        .plus_one  (plus_one),
        .hold_req  (hold_req),
        .count     (cnt),
        .start_val (start_val),
        .enable    (enable),
        .inc       (inc),
        .armed     (armed),
        .running   (running),
        .expired   (expired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // counter256-style plant fed by the DUT controls
    always @(posedge clk) begin
        if (!reset) begin
            cnt <= 8'd0;
        end else if (slow_edge) begin
            if (enable)   cnt <= start_val + 8'(inc);
            else if (inc) cnt <= cnt;
            else          cnt <= cnt - 8'd1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_update();
        int  old_timer;
        bit  old_hold;
        if (!reset) begin
            m_pending = 0; m_counting = 0; m_pulse = 0; m_hold_prev = 0;
            m_pp = 0; m_pv = 0; m_sv = 0; m_timer = 0;
        end else begin
            old_timer = m_timer;
            old_hold  = m_hold_prev;
            if (slow_edge) begin
                if (m_pending) m_timer = m_pv;
                else if (m_counting && !old_hold && old_timer != 0) m_timer = old_timer - 1;
            end
            m_pulse = 0;
            if (load_req) begin
                m_pending  = 1;
                m_counting = 0;
                m_sv       = int'(load_val);
                m_pp       = plus_one;
                m_pv       = (int'(load_val) + int'(plus_one)) % 256;
            end else if (m_pending && slow_edge) begin
                m_pending  = 0;
                m_counting = 1;
            end else if (m_counting && slow_edge && old_timer == 0 && !old_hold) begin
                m_counting = 0;
                m_pulse    = 1;
            end
            m_hold_prev = hold_req;
        end
    endtask

    task automatic compare_all();
        bit exp_inc;
        if (m_pending)       exp_inc = m_pp;
        else if (m_counting) exp_inc = m_hold_prev || (m_timer == 0);
        else                 exp_inc = 1'b1;
        check("enable",    32'(enable),    32'(m_pending));
        check("armed",     32'(armed),     32'(m_pending));
        check("running",   32'(running),   32'(m_counting));
        check("expired",   32'(expired),   32'(m_pulse));
        check("start_val", 32'(start_val), 32'(m_sv));
        check("inc",       32'(inc),       32'(exp_inc));
        check("count",     32'(cnt),       32'(m_timer));
        if (expired === 1'b1) exp_pulses++;
    endtask

    task automatic step(input logic se, input logic lr, input logic [7:0] lv,
                        input logic po, input logic hr);
        slow_edge = se; load_req = lr; load_val = lv; plus_one = po; hold_req = hr;
        @(posedge clk);
        model_update();
        #1;
        compare_all();
    endtask

    task automatic tick(input logic hr);
        step(1'b1, 1'b0, 8'd0, 1'b0, hr);
        repeat (3) step(1'b0, 1'b0, 8'd0, 1'b0, hr);
    endtask

    initial begin
        int p0;
        bit prev_se;
        logic se, lr, po, hr;
        n_vec = 0; n_err = 0; exp_pulses = 0;
        reset = 1'b0;
        slow_edge = 0; load_req = 0; load_val = 0; plus_one = 0; hold_req = 0;

        // reset and idle
        repeat (2) step(0, 0, 8'd0, 0, 0);
        reset = 1'b1;
        check("rst_inc",       32'(inc),       32'd1);
        check("rst_enable",    32'(enable),    32'd0);
        check("rst_start_val", 32'(start_val), 32'd0);
        for (int i = 0; i < 10; i++) step(logic'(i == 4), 0, 8'd0, 0, 0);
        check("idle_count",   32'(cnt),     32'd0);
        check("idle_running", 32'(running), 32'd0);

        // load 5, count down to zero, expire once, stay at 0
        step(0, 1, 8'd5, 0, 0);
        check("ld5_armed", 32'(armed), 32'd1);
        tick(0);
        check("ld5_count", 32'(cnt), 32'd5);
        for (int v = 4; v >= 0; v--) begin
            tick(0);
            check("dn5_count", 32'(cnt), 32'(v));
        end
        p0 = exp_pulses;
        repeat (11) tick(0);
        check("dn5_pulses", 32'(exp_pulses - p0), 32'd1);
        check("dn5_stay0",  32'(cnt), 32'd0);
        check("dn5_inc",    32'(inc), 32'd1);

        // load 3+1, hold across 3 strobes, release
        step(0, 1, 8'd3, 1, 0);
        tick(0);
        check("ld4_count", 32'(cnt), 32'd4);
        step(0, 0, 8'd0, 0, 1);
        repeat (3) tick(1);
        check("hold_count", 32'(cnt), 32'd4);
        step(0, 0, 8'd0, 0, 0);
        for (int v = 3; v >= 0; v--) begin
            tick(0);
            check("dn4_count", 32'(cnt), 32'(v));
        end
        p0 = exp_pulses;
        tick(0);
        check("dn4_pulses", 32'(exp_pulses - p0), 32'd1);

        // load coincident with a strobe, then replace pending value with 9
        step(1, 1, 8'd6, 0, 0);
        check("coinc_count", 32'(cnt),   32'd0);
        check("coinc_armed", 32'(armed), 32'd1);
        step(0, 1, 8'd9, 0, 0);
        step(0, 0, 8'd0, 0, 0);
        tick(0);
        check("ld9_count",   32'(cnt),     32'd9);
        check("ld9_running", 32'(running), 32'd1);

        // reload in RUN at 2, then reload on the terminating strobe
        p0 = exp_pulses;
        repeat (7) tick(0);
        check("at2_count", 32'(cnt), 32'd2);
        step(0, 1, 8'd7, 0, 0);
        check("rl_armed", 32'(armed), 32'd1);
        tick(0);
        check("rl7_count", 32'(cnt), 32'd7);
        repeat (7) tick(0);
        check("at0_count", 32'(cnt), 32'd0);
        step(1, 1, 8'd7, 0, 0);
        check("term_armed",   32'(armed),   32'd1);
        check("term_running", 32'(running), 32'd0);
        repeat (3) step(0, 0, 8'd0, 0, 0);
        check("rl_pulses", 32'(exp_pulses - p0), 32'd0);
        tick(0);
        check("rl7b_count", 32'(cnt), 32'd7);

        // reset mid-countdown, then 255+1 wraps to 0 and expires on first tick
        repeat (4) tick(0);
        check("at3_count", 32'(cnt), 32'd3);
        reset = 1'b0;
        step(0, 0, 8'd0, 0, 0);
        reset = 1'b1;
        check("mrst_running", 32'(running), 32'd0);
        check("mrst_inc",     32'(inc),     32'd1);
        check("mrst_armed",   32'(armed),   32'd0);
        step(0, 1, 8'd255, 1, 0);
        tick(0);
        check("wrap_count",   32'(cnt),     32'd0);
        check("wrap_running", 32'(running), 32'd1);
        p0 = exp_pulses;
        tick(0);
        check("wrap_pulses", 32'(exp_pulses - p0), 32'd1);

        // randomized traffic against the model
        prev_se = 0;
        hr = 0;
        for (int i = 0; i < 3000; i++) begin
            se = !prev_se && ($urandom_range(0, 3) == 0);
            lr = ($urandom_range(0, 19) == 0);
            po = logic'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) hr = ~hr;
            reset = ($urandom_range(0, 499) != 0);
            step(se, lr, 8'($urandom_range(0, 255)), po, hr);
            prev_se = se;
        end
        reset = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/countdown_cmd_gen.md
# countdown_cmd_gen

Command generator for the 8-bit slow-edge down-counter (`counter256`-style countdown timer). It accepts user load and pause requests at full clock rate and turns them into the counter's `start_val`/`enable`/`inc` controls, held stable through the next `slow_edge` strobe. It watches the counter's `count` output so it can stop the count at zero and flag expiry. It is instantiated beside the counter in the game datapath, between the input synchronisers and the counter.

## Interface
Parameters:
- `WIDTH`, default 8: width of the count and load values. Must match the counter.

Ports:
- `clk`  input  1  system clock. All logic is on the rising edge.
- `reset`  input  1  synchronous, active-low reset (0 = reset).
- `slow_edge`  input  1  one-cycle tick strobe, the same signal the counter receives. Consecutive strobes are at least 2 cycles apart.
- `load_req`  input  1  one-cycle pulse requesting a (re)load of the counter.
- `load_val`  input  WIDTH  value to load. Sampled only when `load_req`=1.
- `plus_one`  input  1  sampled with `load_req`. When 1, the counter loads `load_val`+1.
- `hold_req`  input  1  level input that pauses the countdown while high.
- `count`  input  WIDTH  live count fed back from the counter.
- `start_val`  output  WIDTH  load value presented to the counter.
- `enable`  output  1  load command to the counter.
- `inc`  output  1  to counter: with `enable`=1 selects load+1; with `enable`=0 selects hold.
- `armed`  output  1  high while a load is pending.
- `running`  output  1  high while counting down.
- `expired`  output  1  one-cycle pulse when the countdown stops at zero.

## Operation
- FSM states: IDLE, ARMED, RUN, EXPIRED. Encoding is free.
- Registers: `state`, `start_val_q`, `plus_one_q`, `hold_q` (`hold_req` delayed 1 cycle), `expired_q`.
- Output decode:
  - `enable` = (state==ARMED).
  - `start_val` = `start_val_q`.
  - `armed` = (state==ARMED).
  - `running` = (state==RUN).
  - `expired` = `expired_q`.
  - `inc` = `plus_one_q` in ARMED; `hold_q` | (`count`==0) in RUN; 1 in IDLE and EXPIRED.
  - With this decode the counter never decrements outside RUN and never wraps 0 to 255.
- State transitions, in priority order:
  - `load_req`=1 in any state: capture `load_val` into `start_val_q` and `plus_one` into `plus_one_q`; next state is ARMED. A load while ARMED replaces the pending value. A load while RUN or EXPIRED restarts.
  - ARMED with `slow_edge`=1: the counter loads on this edge; next state is RUN.
  - RUN with `slow_edge`=1, `count`==0 and `hold_q`=0: next state is EXPIRED and `expired_q` is set for one cycle.
  - Otherwise, hold the current state.
- `hold_req` only affects RUN. Hold in ARMED is ignored: the load still occurs.
- Arithmetic: none internal. The +1 is done by the counter modulo 2^WIDTH. `load_val`=255 with `plus_one`=1 therefore loads 0 and expires on the first RUN tick.

## Timing
- Reset (`reset`=0 at an edge):
  - state becomes IDLE; `start_val`=0, `enable`=0, `inc`=1, `armed`=0, `running`=0, `expired`=0.
  - Reset overrides `load_req`.
  - Reset mid-countdown drops any pending load and any expiry pulse.
- `load_req` at edge N: `enable`=1 from cycle N+1. It stays high through the first cycle with `slow_edge`=1, then drops at that edge, the same edge at which the counter loads.
- If `load_req` and `slow_edge` are both high in the same cycle, the counter does not load on that strobe. It loads on the next `slow_edge`.
- `hold_req` reaches `inc` with 1 cycle of latency. The `count`==0 term reaches `inc` combinationally, so the counter holds at 0 on the very strobe that would have wrapped it.
- `expired` is high exactly one cycle: the cycle after the terminating strobe edge.
- If `load_req` arrives in the same cycle as a terminating strobe, the load wins: no `expired` pulse and next state is ARMED.
- Loading 0 with `plus_one`=0: RUN is entered, and the first RUN strobe gives EXPIRED with the count still 0.

## Test plan
- Reset, then idle 10 cycles -> `inc`=1, `enable`=0, state IDLE. A strobe during idle leaves the counter model unchanged.
- `load_val`=5, `plus_one`=0, strobes every 4 cycles -> counter reads 5,4,3,2,1,0. `expired` pulses once, the count stays 0 for 10 further strobes, and `inc`=1 throughout.
- `load_val`=3, `plus_one`=1 -> counter loads 4. Holding `hold_req` across 3 strobes freezes the count at 4. Release -> 3,2,1,0, then `expired`.
- `load_req` asserted in the same cycle as `slow_edge` -> the counter is unchanged on that strobe and loads on the next one. A second `load_req` (value 9) while ARMED -> the counter loads 9.
- Reload in RUN at count 2 with `load_val`=7 -> ARMED, then the counter reads 7 at the next strobe and no `expired` pulse occurs. Repeat the reload timed on the terminating strobe -> still no `expired`.
- `reset`=0 mid-countdown at count 3 -> the next cycle shows IDLE and `inc`=1. `load_val`=255 with `plus_one`=1 -> counter loads 0, then `expired` on the first RUN strobe.
